// File: rtl/alu_issue_stage.sv
// alu_issue_stage: MIPS32 decode/issue into the ALU via a 2-entry skid buffer; ALU_ISSUE_PERF_CNT_EN adds issue/stall counters.
module alu_issue_stage #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       instr,
    input  logic [DATA_W-1:0] rs_data,
    input  logic [DATA_W-1:0] rt_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [2:0]        alu_control,
    output logic [REG_AW-1:0] rd_addr,
    output logic              reg_write,
    output logic              illegal
`ifdef ALU_ISSUE_PERF_CNT_EN
    ,
    output logic [31:0]       issue_count,
    output logic [31:0]       stall_count
`endif
);
    localparam logic [1:0] EMPTY = 2'd0, BUSY = 2'd1, FULL = 2'd2;

    typedef struct packed {
        logic              illegal;
        logic              reg_write;
        logic [REG_AW-1:0] rd;
        logic [2:0]        ctrl;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
    } entry_t;

    entry_t      dec, main_q, skid_q;
    logic [1:0]  state, state_nxt;
    logic        legal, accept, issue, load_main, load_skid, pop_skid;
    logic [5:0]  opcode, funct;
    logic [15:0] imm;
    logic        unused_rs_field;

    assign opcode          = instr[31:26];
    assign funct           = instr[5:0];
    assign imm             = instr[15:0];
    assign unused_rs_field = ^instr[25:21];

    assign out_valid = state != EMPTY;
    assign accept    = in_valid && in_ready && !flush;
    assign issue     = out_valid && out_ready;

    always_comb begin
        dec   = '0;
        legal = 1'b1;
        if (opcode == 6'h00) begin
            dec.rd = instr[15:11];
            case (funct)
                6'h20: begin dec.ctrl = 3'b000; dec.a = rs_data; dec.b = rt_data; end
                6'h22: begin dec.ctrl = 3'b001; dec.a = rs_data; dec.b = rt_data; end
                6'h24: begin dec.ctrl = 3'b010; dec.a = rs_data; dec.b = rt_data; end
                6'h25: begin dec.ctrl = 3'b011; dec.a = rs_data; dec.b = rt_data; end
                6'h26: begin dec.ctrl = 3'b100; dec.a = rs_data; dec.b = rt_data; end
                6'h04: begin dec.ctrl = 3'b101; dec.a = rt_data; dec.b = {{(DATA_W-5){1'b0}}, rs_data[4:0]}; end
                6'h06: begin dec.ctrl = 3'b110; dec.a = rt_data; dec.b = {{(DATA_W-5){1'b0}}, rs_data[4:0]}; end
                6'h00: begin dec.ctrl = 3'b101; dec.a = rt_data; dec.b = {{(DATA_W-5){1'b0}}, instr[10:6]}; end
                6'h02: begin dec.ctrl = 3'b110; dec.a = rt_data; dec.b = {{(DATA_W-5){1'b0}}, instr[10:6]}; end
                default: legal = 1'b0;
            endcase
        end else begin
            dec.rd = instr[20:16];
            dec.a  = rs_data;
            case (opcode)
                6'h08: begin dec.ctrl = 3'b000; dec.b = {{(DATA_W-16){imm[15]}}, imm}; end
                6'h0C: begin dec.ctrl = 3'b010; dec.b = {{(DATA_W-16){1'b0}}, imm}; end
                6'h0D: begin dec.ctrl = 3'b011; dec.b = {{(DATA_W-16){1'b0}}, imm}; end
                6'h0E: begin dec.ctrl = 3'b100; dec.b = {{(DATA_W-16){1'b0}}, imm}; end
                default: legal = 1'b0;
            endcase
        end
        // Unsupported encodings still travel the handshake, but as an inert NOP.
        if (!legal) begin
            dec.rd   = '0;
            dec.ctrl = '0;
            dec.a    = '0;
            dec.b    = '0;
        end
        dec.illegal   = !legal;
        dec.reg_write = legal && (dec.rd != '0);
    end

    always_comb begin
        state_nxt = state;
        load_main = 1'b0;
        load_skid = 1'b0;
        pop_skid  = 1'b0;
        if (flush) begin
            state_nxt = EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    state_nxt = accept ? BUSY : EMPTY;
                    load_main = accept;
                end
                BUSY: begin
                    load_main = accept && issue;
                    load_skid = accept && !issue;
                    state_nxt = load_skid ? FULL : (!accept && issue) ? EMPTY : BUSY;
                end
                FULL: begin
                    pop_skid  = issue;
                    state_nxt = issue ? BUSY : FULL;
                end
                default: state_nxt = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= EMPTY;
            in_ready <= 1'b1;
            main_q   <= '0;
            skid_q   <= '0;
        end else begin
            state    <= state_nxt;
            in_ready <= state_nxt != FULL;
            if (load_main)
                main_q <= dec;
            else if (pop_skid)
                main_q <= skid_q;
            if (load_skid)
                skid_q <= dec;
        end
    end

    assign alu_a       = main_q.a;
    assign alu_b       = main_q.b;
    assign alu_control = main_q.ctrl;
    assign rd_addr     = main_q.rd;
    assign reg_write   = main_q.reg_write;
    assign illegal     = main_q.illegal;

`ifdef ALU_ISSUE_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issue_count <= '0;
            stall_count <= '0;
        end else begin
            issue_count <= issue_count + 32'(issue);
            stall_count <= stall_count + 32'(out_valid && !out_ready);
        end
    end
`endif
endmodule

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage: directed plus randomized checks of alu_issue_stage against a queue-based reference model.
module tb_alu_issue_stage;
    logic        clk = 1'b0;
    logic        rst_n, flush, in_valid, out_ready;
    logic [31:0] instr, rs_data, rt_data;
    logic        in_ready, out_valid, reg_write, illegal;
    logic [31:0] alu_a, alu_b;
    logic [2:0]  alu_control;
    logic [4:0]  rd_addr;
`ifdef ALU_ISSUE_PERF_CNT_EN
    logic [31:0] issue_count, stall_count;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic        ill;
        logic        we;
        logic [4:0]  rd;
        logic [2:0]  c;
        logic [31:0] a;
        logic [31:0] b;
    } exp_t;

    exp_t        q[$];
    int unsigned m_issue = 0;
    int unsigned m_stall = 0;

    always #5 clk = ~clk;

    alu_issue_stage dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .rs_data(rs_data), .rt_data(rt_data), .out_valid(out_valid),
        .out_ready(out_ready), .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control),
        .rd_addr(rd_addr), .reg_write(reg_write), .illegal(illegal)
`ifdef ALU_ISSUE_PERF_CNT_EN
        , .issue_count(issue_count), .stall_count(stall_count)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference decode written straight from the instruction table.
    function automatic exp_t model_dec(input logic [31:0] i, input logic [31:0] rs, input logic [31:0] rt);
        exp_t e;
        int   ok;
        e  = '0;
        ok = 1;
        if (i[31:26] == 6'h00) begin
            e.rd = i[15:11];
            case (i[5:0])
                6'h20: begin e.c = 0; e.a = rs; e.b = rt; end
                6'h22: begin e.c = 1; e.a = rs; e.b = rt; end
                6'h24: begin e.c = 2; e.a = rs; e.b = rt; end
                6'h25: begin e.c = 3; e.a = rs; e.b = rt; end
                6'h26: begin e.c = 4; e.a = rs; e.b = rt; end
                6'h04: begin e.c = 5; e.a = rt; e.b = rs % 32; end
                6'h06: begin e.c = 6; e.a = rt; e.b = rs % 32; end
                6'h00: begin e.c = 5; e.a = rt; e.b = 32'(i[10:6]); end
                6'h02: begin e.c = 6; e.a = rt; e.b = 32'(i[10:6]); end
                default: ok = 0;
            endcase
        end else begin
            e.rd = i[20:16];
            e.a  = rs;
            case (i[31:26])
                6'h08: begin e.c = 0; e.b = 32'($signed(i[15:0])); end
                6'h0C: begin e.c = 2; e.b = 32'(i[15:0]); end
                6'h0D: begin e.c = 3; e.b = 32'(i[15:0]); end
                6'h0E: begin e.c = 4; e.b = 32'(i[15:0]); end
                default: ok = 0;
            endcase
        end
        if (ok == 0) begin
            e.c = 0;
            e.a = 0;
            e.b = 0;
        end
        e.ill = (ok == 0);
        e.we  = (ok != 0) && (e.rd != 0);
        return e;
    endfunction

    function automatic logic [31:0] rnd_instr();
        logic [31:0] r;
        logic [5:0]  ops[6] = '{6'h00, 6'h08, 6'h0C, 6'h0D, 6'h0E, 6'h23};
        logic [5:0]  fns[10] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h04, 6'h06, 6'h00, 6'h02, 6'h2A};
        r = $urandom;
        if ($urandom_range(0, 7) != 0) r[31:26] = ops[$urandom_range(0, 5)];
        if ($urandom_range(0, 7) != 0) r[5:0] = fns[$urandom_range(0, 9)];
        return r;
    endfunction

    task automatic compare();
        exp_t e;
        chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
        chk("in_ready", 32'(in_ready), 32'(q.size() < 2));
        if (q.size() > 0) begin
            e = q[0];
            chk("alu_a", alu_a, e.a);
            chk("alu_b", alu_b, e.b);
            chk("alu_control", 32'(alu_control), 32'(e.c));
            chk("illegal", 32'(illegal), 32'(e.ill));
            chk("reg_write", 32'(reg_write), 32'(e.we));
            if (!e.ill) chk("rd_addr", 32'(rd_addr), 32'(e.rd));
        end
`ifdef ALU_ISSUE_PERF_CNT_EN
        chk("issue_count", issue_count, m_issue);
        chk("stall_count", stall_count, m_stall);
`endif
    endtask

    // One clock: predict handshake from the model's occupancy, then check after the edge.
    task automatic tick();
        bit   acc, iss, stall;
        exp_t d;
        acc   = in_valid && (q.size() < 2) && !flush;
        iss   = (q.size() > 0) && out_ready;
        stall = (q.size() > 0) && !out_ready;
        d     = model_dec(instr, rs_data, rt_data);
        @(posedge clk);
        #1;
        if (iss) m_issue++;
        if (stall) m_stall++;
        if (flush) q.delete();
        else begin
            if (iss) q.delete(0);
            if (acc) q.push_back(d);
        end
        compare();
    endtask

    task automatic present(input logic [31:0] i, input logic [31:0] rs, input logic [31:0] rt);
        in_valid = 1'b1;
        instr    = i;
        rs_data  = rs;
        rt_data  = rt;
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        instr = '0; rs_data = '0; rt_data = '0;
        #22;
        chk("rst in_ready", 32'(in_ready), 32'd1);
        chk("rst out_valid", 32'(out_valid), 32'd0);
        chk("rst alu_a", alu_a, 32'd0);
        chk("rst alu_b", alu_b, 32'd0);
        chk("rst ctrl/rd/we/ill", {22'd0, alu_control, rd_addr, reg_write, illegal}, 32'd0);
        rst_n = 1'b1;

        out_ready = 1'b1;
        present(32'h2023FFFC, 32'd10, 32'h5555AAAA);
        tick();
        chk("addi b", alu_b, 32'hFFFFFFFC);
        chk("addi a", alu_a, 32'd10);
        chk("addi rd", 32'(rd_addr), 32'd3);
        chk("addi we", 32'(reg_write), 32'd1);
        present(32'h000511C0, 32'h1234_5678, 32'd1);
        tick();
        chk("sll ctrl", 32'(alu_control), 32'd5);
        chk("sll a", alu_a, 32'd1);
        chk("sll b", alu_b, 32'd7);
        chk("sll rd", 32'(rd_addr), 32'd2);
        present(32'h34228000, 32'h0000_0001, 32'h9);
        tick();
        chk("ori b", alu_b, 32'h0000_8000);
        present(32'h8C220000, 32'hDEAD_BEEF, 32'h1);
        tick();
        chk("lw illegal", 32'(illegal), 32'd1);
        chk("lw we", 32'(reg_write), 32'd0);
        chk("lw ctrl", 32'(alu_control), 32'd0);
        present(32'h00220020, 32'd4, 32'd5);
        tick();
        chk("add r0 we", 32'(reg_write), 32'd0);
        chk("add r0 illegal", 32'(illegal), 32'd0);
        in_valid = 1'b0;
        tick();

        // Back-pressure: main, skid, then a third held upstream until space frees.
        out_ready = 1'b0;
        present(32'h00221820, 32'd1, 32'd100);
        tick();
        present(32'h00432022, 32'd2, 32'd200);
        tick();
        chk("full in_ready", 32'(in_ready), 32'd0);
        present(32'h00642826, 32'd3, 32'd300);
        tick();
        tick();
        out_ready = 1'b1;
        tick();
        tick();
        in_valid = 1'b0;
        tick();
        tick();

        // Flush while FULL, and while BUSY with space available.
        out_ready = 1'b0;
        present(32'h20410011, 32'd7, 32'd0);
        tick();
        present(32'h20420022, 32'd8, 32'd0);
        tick();
        flush = 1'b1;
        present(32'h20430033, 32'd9, 32'd0);
        tick();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        present(32'h20440044, 32'd11, 32'd0);
        tick();
        flush = 1'b1;
        present(32'h20450055, 32'd12, 32'd0);
        tick();
        flush = 1'b0; in_valid = 1'b0;
        tick();

        for (int n = 0; n < 400; n++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 31) == 0);
            instr     = rnd_instr();
            rs_data   = $urandom;
            rt_data   = $urandom;
            tick();
        end
        flush = 1'b0;

        // Asynchronous reset while stalled.
        out_ready = 1'b0;
        present(32'h2001_0001, 32'd1, 32'd0);
        tick();
        tick();
        in_valid = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        chk("async rst out_valid", 32'(out_valid), 32'd0);
        chk("async rst in_ready", 32'(in_ready), 32'd1);
        chk("async rst alu_a", alu_a, 32'd0);
        q.delete();
        m_issue = 0;
        m_stall = 0;
        #3;
        rst_n = 1'b1;

        // Two stall cycles, then run until the fifth issue.
        present(32'h2001_0001, 32'd1, 32'd0);
        tick();
        present(32'h2002_0002, 32'd2, 32'd0);
        tick();
        in_valid = 1'b0;
        tick();
        out_ready = 1'b1;
        present(32'h2003_0003, 32'd3, 32'd0);
        for (int n = 0; n < 20 && m_issue < 5; n++) tick();
`ifdef ALU_ISSUE_PERF_CNT_EN
        chk("perf issue_count", issue_count, 32'd5);
        chk("perf stall_count", stall_count, 32'd2);
`endif
        in_valid = 1'b0;
        tick();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
